// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encoding (RV32M funct3) and FSM state types for muldiv_unit.
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one shift-add or restoring step per cycle
// on a shared 2*W+1-bit accumulator, fixed latency of DATA_WIDTH+1 cycles to out_valid.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  div_by_zero
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  state_e          state_q, state_d;
  op_e             op_q, op_d, op_in;
  logic [2*W:0]    acc_q, acc_d, shl;
  logic [W-1:0]    b_q, b_d, res_q, res_d, m1, m2, quo, rem;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            s1_q, s1_d, sx_q, sx_d, dz_q, dz_d;
  logic            accept, sg1, sg2, n1, n2;
  logic [W:0]      add_s, sub_s;
  logic [2*W-1:0]  prod;
  assign op_in  = op_e'(op);
  assign accept = in_valid && in_ready && !flush;
  assign sg1    = op_in != OP_MULHU && op_in != OP_DIVU && op_in != OP_REMU;
  assign sg2    = sg1 && op_in != OP_MULHSU;
  assign n1     = sg1 && op1[W-1];
  assign n2     = sg2 && op2[W-1];
  assign m1     = n1 ? -op1 : op1;
  assign m2     = n2 ? -op2 : op2;
  // Multiply keeps acc[2W] at zero; divide keeps the partial remainder in acc[2W:W].
  assign add_s  = acc_q[2*W:W] + (acc_q[0] ? {1'b0, b_q} : '0);
  assign shl    = {acc_q[2*W-1:0], 1'b0};
  assign sub_s  = shl[2*W:W] - {1'b0, b_q};
  assign prod   = sx_q ? -acc_q[2*W-1:0] : acc_q[2*W-1:0];
  assign quo    = dz_q ? '1 : sx_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem    = s1_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = in_valid ? S_CALC : S_IDLE;
      S_CALC:  state_d = cnt_q == '0 ? S_FIX : S_CALC;
      S_FIX:   state_d = S_DONE;
      default: state_d = out_ready ? S_IDLE : S_DONE;
    endcase
    if (flush) state_d = S_IDLE;
  end
  always_comb begin
    in_ready    = state_q == S_IDLE;
    out_valid   = state_q == S_DONE;
    result      = res_q;
    div_by_zero = dz_q;
  end
  always_comb begin
    op_d  = op_q;
    acc_d = acc_q;
    b_d   = b_q;
    res_d = res_q;
    cnt_d = cnt_q;
    s1_d  = s1_q;
    sx_d  = sx_q;
    dz_d  = dz_q;
    if (accept) begin
      op_d  = op_in;
      acc_d = {{(W+1){1'b0}}, m1};
      b_d   = m2;
      cnt_d = CW'(W-1);
      s1_d  = n1;
      sx_d  = n1 ^ n2;
      dz_d  = op[2] && op2 == '0;
    end else if (state_q == S_CALC) begin
      acc_d = op_q[2] ? {sub_s[W] ? shl[2*W:W] : sub_s, shl[W-1:1], !sub_s[W]}
                      : {1'b0, add_s, acc_q[W-1:1]};
      cnt_d = cnt_q - CW'(cnt_q != '0);
    end else if (state_q == S_FIX) begin
      res_d = !op_q[2] ? (op_q == OP_MUL ? prod[W-1:0] : prod[2*W-1:W]) : op_q[1] ? rem : quo;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_MUL;
      acc_q <= '0;
      b_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
      s1_q  <= 1'b0;
      sx_q  <= 1'b0;
      dz_q  <= 1'b0;
    end else begin
      op_q  <= op_d;
      acc_q <= acc_d;
      b_q   <= b_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      s1_q  <= s1_d;
      sx_q  <= sx_d;
      dz_q  <= dz_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus flush/reset/stall sequences for muldiv_unit.
module tb_muldiv_unit;
  import muldiv_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [2:0]  op = 3'b0;
  logic [31:0] op1 = '0, op2 = '0, result;
  logic        in_ready, out_valid, div_by_zero;
  int          n_chk = 0, n_fail = 0;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        dz;
    int          hold;
  } vec_t;
  vec_t vecs[22];
  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .op1(op1), .op2(op2), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] r, output logic d, output int lat);
    @(negedge clk);
    op = o; op1 = a; op2 = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); op1 = $urandom; op2 = $urandom;
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    r = result; d = div_by_zero;
    if (lat != 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_result", result, r);
      end
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      chk("handshake_valid", 32'(out_valid), 32'd0);
      chk("handshake_ready", 32'(in_ready), 32'd1);
    end
  endtask
  task automatic no_output(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk(name, 32'(seen), 32'd0);
  endtask
  initial begin
    logic [31:0] r;
    logic        d;
    int          lat;
    vecs[0]  = '{OP_MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, 0};
    vecs[1]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 0};
    vecs[2]  = '{OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 0};
    vecs[3]  = '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 0};
    vecs[4]  = '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 0};
    vecs[5]  = '{OP_DIVU,   32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1'b1, 0};
    vecs[6]  = '{OP_REMU,   32'h12345678, 32'h00000000, 32'h12345678, 1'b1, 0};
    vecs[7]  = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 5};
    vecs[8]  = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 5};
    vecs[9]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0};
    vecs[10] = '{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 0};
    vecs[11] = '{OP_MULH,   32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 0};
    vecs[12] = '{OP_MULHU,  32'h80000000, 32'h00000004, 32'h00000002, 1'b0, 0};
    vecs[13] = '{OP_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 0};
    vecs[14] = '{OP_REM,    32'd100,      32'hFFFFFFF9, 32'h00000002, 1'b0, 0};
    vecs[15] = '{OP_DIVU,   32'd100,      32'd7,        32'd14,       1'b0, 0};
    vecs[16] = '{OP_REMU,   32'd100,      32'd7,        32'd2,        1'b0, 0};
    vecs[17] = '{OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 2};
    vecs[18] = '{OP_REM,    32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 1'b1, 0};
    vecs[19] = '{OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 1'b0, 0};
    vecs[20] = '{OP_MULHU,  32'h12345678, 32'h00000010, 32'h00000001, 1'b0, 0};
    vecs[21] = '{OP_MULHSU, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 1'b0, 0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold, r, d, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd33);
      chk($sformatf("vec%0d_result", i), r, vecs[i].r);
      chk($sformatf("vec%0d_dz", i), 32'(d), 32'(vecs[i].dz));
    end
    // flush during CALC cycle 10
    @(negedge clk); op = OP_DIV; op1 = 32'd1000; op2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_calc_ready", 32'(in_ready), 32'd1);
    chk("flush_calc_valid", 32'(out_valid), 32'd0);
    no_output("flush_calc_no_out", 40);
    // flush together with in_valid in IDLE must not accept
    @(negedge clk); op = OP_MUL; op1 = 32'd3; op2 = 32'd4; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_ready", 32'(in_ready), 32'd1);
    no_output("flush_idle_no_out", 40);
    // async reset while in FIX
    @(negedge clk); op = OP_DIVU; op1 = 32'd77; op2 = 32'd0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (32) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("rst_fix_ready", 32'(in_ready), 32'd1);
    chk("rst_fix_valid", 32'(out_valid), 32'd0);
    chk("rst_fix_result", result, 32'd0);
    chk("rst_fix_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    no_output("rst_fix_no_out", 40);
    chk("rst_fix_ready_after", 32'(in_ready), 32'd1);
    run_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, r, d, lat);
    chk("post_latency", 32'(lat), 32'd33);
    chk("post_result", r, 32'hFFFFFFFF);
    chk("post_dz", 32'(d), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand and result width; SHALL be an even number of at least 8.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  request present on op/op1/op2.
REQ-005 Port: in_ready  output  1  unit can accept a request.
REQ-006 Port: op  input  3  operation, RV32M funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port: op1  input  DATA_WIDTH  rs1 operand (multiplicand or dividend).
REQ-008 Port: op2  input  DATA_WIDTH  rs2 operand (multiplier or divisor).
REQ-009 Port: flush  input  1  synchronous abort of any in-flight or held operation.
REQ-010 Port: out_valid  output  1  result is valid.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: result  output  DATA_WIDTH  operation result.
REQ-013 Port: div_by_zero  output  1  held result came from DIV/DIVU/REM/REMU with op2==0; qualified by out_valid.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, CALC, FIX, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a request SHALL be accepted on an edge where in_valid && in_ready.
REQ-016 On acceptance, the unit SHALL latch op, operand magnitudes and result-sign flags, load the iteration counter with DATA_WIDTH-1, and enter CALC.
REQ-017 CALC SHALL perform one shift-add (multiply) or restoring subtract-shift (divide) step per cycle, leave CALC after exactly DATA_WIDTH cycles, and enter FIX.
REQ-018 FIX SHALL apply two's-complement sign correction, select the upper/lower half or the quotient/remainder, write result, and enter DONE.
REQ-019 Latency SHALL be fixed for every op, including special cases: for acceptance at edge k, out_valid SHALL be 1 after edge k+DATA_WIDTH+1.
REQ-020 In DONE, out_valid=1 and result/div_by_zero SHALL stay stable until out_valid && out_ready, then return to IDLE; in_ready rises the next cycle (no same-cycle back-to-back).
REQ-021 Signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU uses signed op1 and unsigned op2; MULHU/DIVU/REMU use unsigned operands.
REQ-022 MUL SHALL return the low DATA_WIDTH bits of the 2*DATA_WIDTH product; MULH* SHALL return the high DATA_WIDTH bits.
REQ-023 Division SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-024 Divide by zero: quotient = all ones; remainder = op1; div_by_zero = 1.
REQ-025 Signed overflow (op1 = most-negative, op2 = -1, DIV/REM): quotient = op1, remainder = 0, div_by_zero = 0.
REQ-026 flush SHALL take priority over all other events: next state IDLE, out_valid=0, and the in-flight or held result discarded.
REQ-027 flush asserted with in_valid in IDLE SHALL NOT accept the request.
REQ-028 Inputs op/op1/op2 SHALL be ignored outside the acceptance edge.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, in_ready=1, out_valid=0, result=0, div_by_zero=0, counter=0, all datapath registers 0.
REQ-030 Reset mid-operation SHALL discard the operation, with no output pulse after release.

Structure
REQ-031 Package muldiv_pkg SHALL hold the op enum (funct3 values) and the FSM state enum; DATA_WIDTH stays a module parameter.
REQ-032 Single module, no sub-modules; the datapath SHALL be one 2*DATA_WIDTH+1-bit accumulator shared by multiply and divide.

Verification
REQ-033 MULH op1=0xFFFFFFFF (-1), op2=0x00000002 -> result 0xFFFFFFFF; out_valid after edge k+33.
REQ-034 MULHU op1=0xFFFFFFFF, op2=0xFFFFFFFF -> 0xFFFFFFFE; MUL with the same operands -> 0x00000001.
REQ-035 DIV op1=-7 (0xFFFFFFF9), op2=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-036 DIVU op1=0x12345678, op2=0 -> 0xFFFFFFFF, div_by_zero=1; REMU with the same operands -> 0x12345678.
REQ-037 DIV op1=0x80000000, op2=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; out_ready held 0 for 5 cycles -> result stable throughout.
REQ-038 flush in CALC cycle 10, and rst_n pulsed low in FIX -> no out_valid, in_ready=1 next cycle; a new MULHSU op1=-1, op2=0xFFFFFFFF -> 0xFFFFFFFF.
